// File: rtl/instruction_encoder_loader_if.sv
// Field-set input, instruction-memory write port and status of the instruction encoder/loader.
interface instruction_encoder_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [6:0]            opcode;
  logic                  rw;
  logic [1:0]            md;
  logic [1:0]            bs;
  logic                  ps;
  logic                  mw;
  logic [4:0]            fs;
  logic                  ma;
  logic                  mb;
  logic [4:0]            aa;
  logic [4:0]            ba;
  logic                  cs;
  logic                  load_addr;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  imem_ready;
  logic                  busy;
  logic                  mem_full;
  logic [ADDR_WIDTH:0]   words_written;

  modport slave (
    input  in_valid, opcode, rw, md, bs, ps, mw, fs, ma, mb, aa, ba, cs,
    input  load_addr, start_addr, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, mem_full, words_written
  );

  modport master (
    output in_valid, opcode, rw, md, bs, ps, mw, fs, ma, mb, aa, ba, cs,
    output load_addr, start_addr, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, mem_full, words_written
  );
endinterface

// File: rtl/instruction_encoder_loader.sv
// Packs control fields into 32-bit words, buffers them in a FIFO and writes them to
// sequential instruction-memory addresses under a ready handshake.
module instruction_encoder_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic                         clk,
  input logic                         reset,
  instruction_encoder_loader_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WW_W  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HALT} state_e;

  state_e                state_q;
  logic [31:0]           fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  in_ready_q, we_q, we_d, busy_q, full_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, head_d, word_c;
  logic [WW_W-1:0]       ww_q;
  logic                  push_c, pop_c, load_ok_c, at_top_c, nonempty_d;

  // FIFO bookkeeping and the word that will sit at the head after this edge
  always_comb begin
    word_c     = {bus.opcode, bus.rw, bus.md, bus.bs, bus.ps, bus.mw,
                  bus.fs, bus.ma, bus.mb, bus.aa, bus.ba, bus.cs};
    push_c     = bus.in_valid && in_ready_q;
    pop_c      = we_q && bus.imem_ready;
    load_ok_c  = bus.load_addr && !we_q;
    at_top_c   = (addr_q == {ADDR_WIDTH{1'b1}});
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
    count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    nonempty_d = (count_d != '0);
    head_d     = (push_c && (wr_ptr_q == rd_ptr_d)) ? word_c : fifo_q[rd_ptr_d];
    we_d       = 1'b0;
    case (state_q)
      S_IDLE:  we_d = !load_ok_c && nonempty_d;
      S_WRITE: we_d = !(pop_c && (at_top_c || !nonempty_d));
      default: we_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= word_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ww_q       <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + PTR_W'(push_c);
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
      we_q       <= we_d;
      busy_q     <= nonempty_d || we_d;
      case (state_q)
        S_IDLE: begin
          if (load_ok_c) begin
            addr_q <= bus.start_addr;
            ww_q   <= '0;
            full_q <= 1'b0;
          end else if (nonempty_d) begin
            state_q <= S_WRITE;
            wdata_q <= head_d;
          end
        end
        S_WRITE: begin
          if (pop_c) begin
            ww_q <= ww_q + WW_W'(1);
            if (at_top_c) begin
              state_q <= S_HALT;
              full_q  <= 1'b1;
            end else begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
              if (nonempty_d) wdata_q <= head_d;
              else            state_q <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          // Words stay buffered until a new base address is loaded
          if (load_ok_c) begin
            state_q <= S_IDLE;
            addr_q  <= bus.start_addr;
            ww_q    <= '0;
            full_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.imem_we       = we_q;
  assign bus.imem_addr     = addr_q;
  assign bus.imem_wdata    = wdata_q;
  assign bus.busy          = busy_q;
  assign bus.mem_full      = full_q;
  assign bus.words_written = ww_q;
endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed bench for instruction_encoder_loader: queue-based reference model checked every
// cycle, plus literal expectations at key points.
module tb_instruction_encoder_loader;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  instruction_encoder_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_encoder_loader #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of packed words plus write-side bookkeeping
  logic [31:0] m_q [$];
  int          m_addr;
  int          m_ww;
  bit          m_full, m_we, m_ok = 1'b0;
  bit          m_pop, m_push, m_ld;
  logic [31:0] m_word;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_addr = 0; m_ww = 0; m_full = 1'b0; m_we = 1'b0; m_ok = 1'b1;
    end else if (m_ok) begin
      m_word = {bus.opcode, bus.rw, bus.md, bus.bs, bus.ps, bus.mw,
                bus.fs, bus.ma, bus.mb, bus.aa, bus.ba, bus.cs};
      m_push = bus.in_valid && (m_q.size() < DEPTH);
      m_pop  = m_we && bus.imem_ready;
      m_ld   = bus.load_addr && !m_we;
      if (m_pop) begin
        void'(m_q.pop_front());
        m_ww++;
        if (m_addr == (1 << AW) - 1) m_full = 1'b1;
        else                         m_addr++;
      end
      if (m_ld) begin
        m_addr = int'(bus.start_addr); m_full = 1'b0; m_ww = 0;
      end
      if (m_push) m_q.push_back(m_word);
      m_we = !m_full && (m_q.size() > 0) && !m_ld;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("in_ready", 64'(bus.in_ready), 64'(m_q.size() < DEPTH));
      chk("imem_we", 64'(bus.imem_we), 64'(m_we));
      chk("imem_addr", 64'(bus.imem_addr), 64'(m_addr));
      chk("busy", 64'(bus.busy), 64'((m_q.size() > 0) || m_we));
      chk("mem_full", 64'(bus.mem_full), 64'(m_full));
      chk("words_written", 64'(bus.words_written), 64'(m_ww));
      if (m_we) chk("imem_wdata", 64'(bus.imem_wdata), 64'(m_q[0]));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_word(input logic [31:0] w);
    bus.opcode = w[31:25]; bus.rw = w[24];    bus.md = w[23:22]; bus.bs = w[21:20];
    bus.ps     = w[19];    bus.mw = w[18];    bus.fs = w[17:13]; bus.ma = w[12];
    bus.mb     = w[11];    bus.aa = w[10:6];  bus.ba = w[5:1];   bus.cs = w[0];
  endtask

  task automatic push_word(input logic [31:0] w);
    logic rdy;
    int   n = 0;
    set_word(w);
    bus.in_valid = 1'b1;
    do begin
      rdy = bus.in_ready;
      cyc();
      n++;
    end while (!rdy && n < 200);
    if (!rdy) chk("push_timeout", 64'(rdy), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a);
    bus.load_addr  = 1'b1;
    bus.start_addr = a;
    cyc();
    bus.load_addr  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin cyc(); n++; end
    if (bus.busy) chk("drain_timeout", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.load_addr = 1'b0; bus.start_addr = '0; bus.imem_ready = 1'b1;
    set_word(32'h0);
    repeat (3) cyc();
    reset = 1'b0;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_we", 64'(bus.imem_we), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_full", 64'(bus.mem_full), 64'd0);
    chk("rst_ww", 64'(bus.words_written), 64'd0);

    // Packing with individually driven fields
    bus.opcode = 7'h12; bus.rw = 1'b1; bus.md = 2'b01; bus.bs = 2'b00; bus.ps = 1'b0;
    bus.mw = 1'b0; bus.fs = 5'h05; bus.ma = 1'b0; bus.mb = 1'b1; bus.aa = 5'd3;
    bus.ba = 5'd4; bus.cs = 1'b1; bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("pack_we", 64'(bus.imem_we), 64'd1);
    chk("pack_addr", 64'(bus.imem_addr), 64'd0);
    chk("pack_wdata", 64'(bus.imem_wdata), 64'h2540A8C9);
    cyc();
    chk("pack_ww", 64'(bus.words_written), 64'd1);
    chk("pack_we_off", 64'(bus.imem_we), 64'd0);
    push_word(32'hFFFF_FFFF);
    chk("ones_wdata", 64'(bus.imem_wdata), 64'hFFFF_FFFF);
    chk("ones_addr", 64'(bus.imem_addr), 64'd1);
    wait_idle();

    // Burst of six back-to-back words from address 0
    load(8'h00);
    for (int i = 0; i < 6; i++) begin
      chk("burst_rdy", 64'(bus.in_ready), 64'd1);
      push_word(32'hC0DE_0000 | 32'(i));
    end
    wait_idle();
    chk("burst_ww", 64'(bus.words_written), 64'd6);
    chk("burst_addr", 64'(bus.imem_addr), 64'd6);

    // Backpressure: four fill the FIFO, fifth waits; load_addr during stall is ignored
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'hB000_0000 | 32'(i));
    chk("bp_full_rdy", 64'(bus.in_ready), 64'd0);
    fork
      push_word(32'hB000_0004);
      begin
        repeat (2) cyc();
        chk("bp_hold_addr", 64'(bus.imem_addr), 64'h06);
        chk("bp_hold_wdata", 64'(bus.imem_wdata), 64'hB000_0000);
        load(8'h55);
        chk("bp_load_ign", 64'(bus.imem_addr), 64'h06);
        bus.imem_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_end_addr", 64'(bus.imem_addr), 64'h0B);
    chk("bp_end_ww", 64'(bus.words_written), 64'd11);

    // Wrap to the top address and halt, then resume from a new base
    load(8'hFE);
    for (int i = 0; i < 3; i++) push_word(32'hE000_0000 | 32'(i));
    begin
      int n = 0;
      while (!bus.mem_full && n < 50) begin cyc(); n++; end
    end
    repeat (2) cyc();
    chk("halt_full", 64'(bus.mem_full), 64'd1);
    chk("halt_we", 64'(bus.imem_we), 64'd0);
    chk("halt_addr", 64'(bus.imem_addr), 64'hFF);
    chk("halt_ww", 64'(bus.words_written), 64'd2);
    chk("halt_busy", 64'(bus.busy), 64'd1);
    load(8'h10);
    chk("reload_full", 64'(bus.mem_full), 64'd0);
    cyc();
    chk("reload_we", 64'(bus.imem_we), 64'd1);
    chk("reload_addr", 64'(bus.imem_addr), 64'h10);
    chk("reload_wdata", 64'(bus.imem_wdata), 64'hE000_0002);
    wait_idle();
    chk("reload_ww", 64'(bus.words_written), 64'd1);

    // Reset in the middle of a stalled burst
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'hD000_0000 | 32'(i));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_we", 64'(bus.imem_we), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_rdy", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_ww", 64'(bus.words_written), 64'd0);
    bus.imem_ready = 1'b1;
    push_word(32'h1234_5678);
    chk("post_rst_we", 64'(bus.imem_we), 64'd1);
    chk("post_rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("post_rst_wdata", 64'(bus.imem_wdata), 64'h1234_5678);
    wait_idle();
    chk("post_rst_ww", 64'(bus.words_written), 64'd1);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
